// File: rtl/move_defs.sv
// Shared definitions for the cube-turning move sequencer.
// Holds the face codes, the bit layout of a move code and the FSM state encoding.
package move_defs;

  // Face codes carried in the move-code face field
  localparam logic [2:0] FaceR = 3'd1;
  localparam logic [2:0] FaceU = 3'd2;
  localparam logic [2:0] FaceF = 3'd3;
  localparam logic [2:0] FaceL = 3'd4;
  localparam logic [2:0] FaceB = 3'd5;
  localparam logic [2:0] FaceD = 3'd6;

  // Move-code layout: [4] half turn, [3:1] face, [0] inverse
  localparam int unsigned MoveCodeW   = 5;
  localparam int unsigned MoveInvBit  = 0;
  localparam int unsigned MoveFaceLsb = 1;
  localparam int unsigned MoveFaceMsb = 3;
  localparam int unsigned MoveHalfBit = 4;

  // Step counter width; a half turn of 2*1023 steps still fits
  localparam int unsigned StepCntW = 11;
  localparam int unsigned SettleW  = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStepHi = 3'd1,
    StStepLo = 3'd2,
    StSettle = 3'd3,
    StDone   = 3'd4
  } state_e;

endpackage

// File: rtl/step_pulse_gen.sv
// Step-phase timer for the shared step output.
// While start is high it alternates high and low phases of 'period' cycles each,
// beginning with a high phase; step_tick marks the last cycle of every phase.
// Dropping start returns it to the ready-for-high-phase condition.
//   clock, reset     : clock and synchronous active-high reset
//   period           : cycles per phase (>= 1)
//   start            : run enable, held high for the whole stepping interval
//   step_pin         : step output, low whenever start is low
//   step_tick        : one-cycle marker at the end of each phase
module step_pulse_gen #(
  parameter int unsigned PERIOD_W = 20
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] period,
  input  logic                start,
  output logic                step_pin,
  output logic                step_tick
);

  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic                phase_hi_q, phase_hi_d;

  always_comb begin
    timer_d    = timer_q;
    phase_hi_d = phase_hi_q;
    step_tick  = 1'b0;
    if (!start) begin
      timer_d    = '0;
      phase_hi_d = 1'b1;
    end else if (timer_q == period - PERIOD_W'(1)) begin
      step_tick  = 1'b1;
      timer_d    = '0;
      phase_hi_d = ~phase_hi_q;
    end else begin
      timer_d = timer_q + PERIOD_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q    <= '0;
      phase_hi_q <= 1'b1;
    end else begin
      timer_q    <= timer_d;
      phase_hi_q <= phase_hi_d;
    end
  end

  assign step_pin = start & phase_hi_q;

endmodule

// File: rtl/move_sequencer.sv
// Executes one cube move at a time on a bank of stepper drivers sharing a
// step line. A move enables one face driver, sets direction, issues a quarter
// or half turn worth of step pulses, holds the enable for a settle time and
// then pulses move_done. Invalid face codes are rejected with move_error.
//   clock, reset : clock and synchronous active-high reset
//   next_move    : [4] half turn, [3:1] face 1..NUM_FACES, [0] inverse
//   move_start   : request, honoured only while move_ready is high
//   move_ready   : idle, request accepted this cycle
//   move_done    : one-cycle completion pulse
//   move_error   : one-cycle pulse the cycle after an invalid request
//   dir_pin      : direction latched at accept
//   step_pin     : shared step pulse train
//   en_pins      : one-hot driver enable
module move_sequencer
  import move_defs::*;
#(
  parameter int unsigned NUM_FACES        = 6,
  parameter int unsigned QUARTER_STEPS    = 50,
  parameter int unsigned STEP_HALF_PERIOD = 31250,
  parameter int unsigned SETTLE_CYCLES    = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [MoveCodeW-1:0] next_move,
  input  logic                 move_start,
  output logic                 move_ready,
  output logic                 move_done,
  output logic                 move_error,
  output logic                 dir_pin,
  output logic                 step_pin,
  output logic [NUM_FACES-1:0] en_pins
);

  localparam int unsigned PeriodW = $clog2(STEP_HALF_PERIOD + 1);
  localparam logic [PeriodW-1:0]  HalfPeriod    = PeriodW'(STEP_HALF_PERIOD);
  localparam logic [StepCntW-1:0] QuarterTarget = StepCntW'(QUARTER_STEPS);
  localparam logic [StepCntW-1:0] HalfTarget    = StepCntW'(2 * QUARTER_STEPS);
  // Only meaningful when SETTLE_CYCLES > 0; the settle state is skipped otherwise
  localparam logic [SettleW-1:0]  SettleLast    = SettleW'(SETTLE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [2:0]           face_q, face_d;
  logic                 dir_q, dir_d;
  logic [StepCntW-1:0]  target_q, target_d;
  logic [StepCntW-1:0]  count_q, count_d;
  logic [SettleW-1:0]   settle_q, settle_d;
  logic                 error_q, error_d;

  logic       step_run;
  logic       step_tick;
  logic       en_active;
  logic [2:0] face_code;
  logic       face_ok;

  assign face_code = next_move[MoveFaceMsb:MoveFaceLsb];
  assign face_ok   = (face_code != 3'd0) && (32'(face_code) <= NUM_FACES);

  step_pulse_gen #(
    .PERIOD_W (PeriodW)
  ) u_step_pulse_gen (
    .clock     (clock),
    .reset     (reset),
    .period    (HalfPeriod),
    .start     (step_run),
    .step_pin  (step_pin),
    .step_tick (step_tick)
  );

  always_comb begin
    state_d   = state_q;
    face_d    = face_q;
    dir_d     = dir_q;
    target_d  = target_q;
    count_d   = count_q;
    settle_d  = settle_q;
    error_d   = 1'b0;
    step_run  = 1'b0;
    en_active = 1'b0;
    move_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (move_start) begin
          if (face_ok) begin
            face_d   = face_code - 3'd1;
            dir_d    = ~next_move[MoveInvBit];
            target_d = next_move[MoveHalfBit] ? HalfTarget : QuarterTarget;
            count_d  = '0;
            state_d  = StStepHi;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      StStepHi: begin
        step_run  = 1'b1;
        en_active = 1'b1;
        if (step_tick) state_d = StStepLo;
      end
      StStepLo: begin
        step_run  = 1'b1;
        en_active = 1'b1;
        if (step_tick) begin
          // A pulse counts as complete at the end of its low phase
          count_d = count_q + StepCntW'(1);
          if (count_d == target_q) begin
            settle_d = '0;
            state_d  = (SETTLE_CYCLES == 0) ? StDone : StSettle;
          end else begin
            state_d = StStepHi;
          end
        end
      end
      StSettle: begin
        en_active = 1'b1;
        if (settle_q == SettleLast) state_d = StDone;
        else                        settle_d = settle_q + SettleW'(1);
      end
      StDone: begin
        move_done = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      face_q   <= '0;
      dir_q    <= 1'b0;
      target_q <= '0;
      count_q  <= '0;
      settle_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      face_q   <= face_d;
      dir_q    <= dir_d;
      target_q <= target_d;
      count_q  <= count_d;
      settle_q <= settle_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    en_pins = '0;
    for (int unsigned i = 0; i < NUM_FACES; i++) begin
      en_pins[i] = en_active && (32'(face_q) == i);
    end
  end

  assign move_ready = (state_q == StIdle);
  assign move_error = error_q;
  assign dir_pin    = dir_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Randomised scoreboard bench for move_sequencer. The driver issues moves and
// pushes the expected outcome of each into a queue; a monitor watches the
// outputs every cycle and checks each move_done / move_error against it.
module tb_move_sequencer;

  localparam int NF = 6;
  localparam int QS = 4;
  localparam int HP = 2;
  localparam int SC = 3;

  typedef struct {
    bit         err;
    logic [5:0] en;
    bit         dir;
    int         pulses;
    int         lat;
  } exp_t;

  logic       clock;
  logic       reset;
  logic [4:0] next_move;
  logic       move_start;
  logic       move_ready;
  logic       move_done;
  logic       move_error;
  logic       dir_pin;
  logic       step_pin;
  logic [5:0] en_pins;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  exp_t exp_q[$];
  int   acc_q[$];

  move_sequencer #(
    .NUM_FACES        (NF),
    .QUARTER_STEPS    (QS),
    .STEP_HALF_PERIOD (HP),
    .SETTLE_CYCLES    (SC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .next_move  (next_move),
    .move_start (move_start),
    .move_ready (move_ready),
    .move_done  (move_done),
    .move_error (move_error),
    .dir_pin    (dir_pin),
    .step_pin   (step_pin),
    .en_pins    (en_pins)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event, expected none (cycle %0d)", name, cycle);
  endtask

  // Outcome of a move derived from the move-code rules
  function automatic exp_t model(input logic [4:0] code);
    exp_t e;
    int   face;
    int   steps;
    face = int'(code[3:1]);
    if (face < 1 || face > NF) begin
      e.err = 1'b1; e.en = '0; e.dir = 1'b0; e.pulses = 0; e.lat = 1;
    end else begin
      steps    = code[4] ? 2 * QS : QS;
      e.err    = 1'b0;
      e.en     = 6'(1) << (face - 1);
      e.dir    = !code[0];
      e.pulses = steps;
      e.lat    = 1 + 2 * HP * steps + SC;
    end
    return e;
  endfunction

  // Monitor: accumulates pin activity between events and scores each event
  initial begin
    int         pulses_seen;
    int         hi_seen;
    int         en_seen;
    logic [5:0] en_or;
    logic       prev_step;
    exp_t       e;
    int         a;
    pulses_seen = 0; hi_seen = 0; en_seen = 0; en_or = '0; prev_step = 1'b0;
    forever begin
      @(negedge clock);
      if (reset === 1'b1) begin
        acc_q.delete();
        pulses_seen = 0; hi_seen = 0; en_seen = 0; en_or = '0; prev_step = 1'b0;
      end else begin
        if (step_pin === 1'b1 && prev_step !== 1'b1) pulses_seen++;
        if (step_pin === 1'b1) hi_seen++;
        if (en_pins !== 6'b0) begin
          en_seen++;
          en_or = en_or | en_pins;
        end
        prev_step = step_pin;
        if (move_done === 1'b1 || move_error === 1'b1) begin
          if (exp_q.size() == 0 || acc_q.size() == 0) begin
            fail_now("unexpected_event");
          end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            chk("event_is_error", 32'(move_error), 32'(e.err));
            chk("event_is_done", 32'(move_done), 32'(!e.err));
            chk("latency", 32'(cycle - a), 32'(e.lat));
            chk("step_pulses", 32'(pulses_seen), 32'(e.pulses));
            chk("step_high_cycles", 32'(hi_seen), 32'(HP * e.pulses));
            chk("en_cycles", 32'(en_seen), 32'(e.err ? 0 : e.lat - 1));
            chk("en_face", 32'(en_or), 32'(e.en));
            if (!e.err) chk("dir_pin", 32'(dir_pin), 32'(e.dir));
          end
          pulses_seen = 0; hi_seen = 0; en_seen = 0; en_or = '0;
        end
        if (move_ready === 1'b1 && move_start === 1'b1) acc_q.push_back(cycle);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (move_ready !== 1'b1 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (move_ready !== 1'b1) fail_now("ready_timeout");
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Issue one move; while it runs, optionally scramble the inputs
  task automatic issue(input logic [4:0] code, input bit rand_busy);
    exp_t e;
    wait_ready();
    e = model(code);
    next_move  = code;
    move_start = 1'b1;
    exp_q.push_back(e);
    if (!e.err) begin
      for (int c = 1; c <= e.lat; c++) begin
        @(posedge clock); #1;
        move_start = rand_busy ? 1'($urandom) : 1'b0;
        next_move  = 5'($urandom);
      end
    end
    @(posedge clock); #1;
    move_start = 1'b0;
    next_move  = 5'($urandom);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; move_start = 1'b0; next_move = 5'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_ready", 32'(move_ready), 32'd1);
    chk("reset_en", 32'(en_pins), 32'd0);
    chk("reset_step", 32'(step_pin), 32'd0);
    chk("reset_dir", 32'(dir_pin), 32'd0);
    chk("reset_done", 32'(move_done), 32'd0);
    chk("reset_error", 32'(move_error), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Directed moves: R quarter, U half inverse, then two invalid codes
    issue(5'b00010, 1'b0);
    issue(5'b10101, 1'b1);
    issue(5'b00000, 1'b0);
    issue(5'b01110, 1'b0);
    drain();

    // Reset during a move aborts it without a done pulse
    wait_ready();
    next_move  = 5'b00010;
    move_start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clock); #1;
      move_start = 1'b0;
    end
    chk("abort_en_before", 32'(en_pins), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort_en", 32'(en_pins), 32'd0);
    chk("abort_step", 32'(step_pin), 32'd0);
    chk("abort_ready", 32'(move_ready), 32'd1);
    chk("abort_done", 32'(move_done), 32'd0);
    repeat (40) @(posedge clock);
    #1;

    // move_start held high: one move per idle window, back to back
    wait_ready();
    e = model(5'b00110);
    next_move  = 5'b00110;
    move_start = 1'b1;
    exp_q.push_back(e);
    exp_q.push_back(e);
    for (int c = 1; c <= e.lat; c++) begin
      @(posedge clock); #1;
    end
    chk("hold_done_now", 32'(move_done), 32'd1);
    chk("hold_busy_at_done", 32'(move_ready), 32'd0);
    @(posedge clock); #1;
    chk("hold_reaccept", 32'(move_ready), 32'd1);
    @(posedge clock); #1;
    move_start = 1'b0;
    chk("hold_second_running", 32'(move_ready), 32'd0);
    drain();

    // Random moves with scrambled inputs while busy
    for (int i = 0; i < 14; i++) begin
      issue(5'($urandom), 1'b1);
    end
    drain();
    repeat (5) @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 Parameter NUM_FACES, default 6: number of stepper channels, one per cube face.
REQ-002 Parameter QUARTER_STEPS, default 50: step pulses per quarter turn, range 1..1023.
REQ-003 Parameter STEP_HALF_PERIOD, default 31250: clock cycles for each high phase and each low phase of step_pin, range 1..2^20-1.
REQ-004 Parameter SETTLE_CYCLES, default 10: cycles that en_pins stays asserted after the last step, range 0..255.
REQ-005 Port clock, input, 1: system clock; all logic on the rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port next_move, input, 5: move code; [4] half-turn flag, [3:1] face code (1..NUM_FACES valid), [0] inverse flag.
REQ-008 Port move_start, input, 1: move request, sampled only while move_ready=1.
REQ-009 Port move_ready, output, 1: block is idle and accepts a request this cycle.
REQ-010 Port move_done, output, 1: one-cycle pulse when a move completes.
REQ-011 Port move_error, output, 1: one-cycle pulse when an invalid face code is rejected.
REQ-012 Port dir_pin, output, 1: stepper direction, latched at accept.
REQ-013 Port step_pin, output, 1: shared step pulse train.
REQ-014 Port en_pins, output, NUM_FACES: one-hot, active-high driver enable.

Function
REQ-015 FSM states SHALL be IDLE, STEP_HI, STEP_LO, SETTLE and DONE.
REQ-016 Accept SHALL occur when state=IDLE and move_start=1 and reset=0.
REQ-017 On accept with face code in 1..NUM_FACES: latch face index = code-1, dir_pin = !next_move[0], target = QUARTER_STEPS, or 2*QUARTER_STEPS if [4]=1; next state STEP_HI.
REQ-018 On accept with face code 0 or > NUM_FACES: move_error=1 for the next cycle only; no en, step or done activity; FSM stays in IDLE.
REQ-019 Timing: move_ready=1 only in IDLE; move_start outside IDLE SHALL be ignored, with no queueing and no error.
REQ-020 en_pins[face]=1 from the first STEP_HI cycle through the last SETTLE cycle; all other bits are 0.
REQ-021 STEP_HI: step_pin=1 for STEP_HALF_PERIOD cycles, then STEP_LO.
REQ-022 STEP_LO: step_pin=0 for STEP_HALF_PERIOD cycles, then the step counter increments; if count=target go to SETTLE, else STEP_HI.
REQ-023 SETTLE lasts SETTLE_CYCLES cycles; when SETTLE_CYCLES=0 it is skipped and the FSM goes directly to DONE.
REQ-024 DONE lasts one cycle: move_done=1, en_pins=0, step_pin=0; next state IDLE.
REQ-025 Latency from accept edge to move_done high SHALL be 1 + 2*STEP_HALF_PERIOD*target + SETTLE_CYCLES cycles.
REQ-026 Step counter is 11 bits and SHALL never wrap; timer width is sized from STEP_HALF_PERIOD with no overflow.
REQ-027 Changes on next_move after accept SHALL have no effect on the move in progress.

Reset
REQ-028 On reset: state IDLE, counters 0, step_pin=0, dir_pin=0, en_pins=0, move_done=0, move_error=0, move_ready=1 from the following cycle.
REQ-029 Reset during a move SHALL abort it at the next edge with no move_done pulse; reset wins over a simultaneous move_start.

Structure
REQ-030 Shared package move_defs SHALL hold the face-code constants (R=1, U=2, F=3, L=4, B=5, D=6), the move-code field positions and the FSM state encoding.
REQ-031 Step timing SHALL live in one sub-module, step_pulse_gen: inputs period, start; outputs step_pin and step_tick.

Verification
REQ-032 Bench parameters SHALL be QUARTER_STEPS=4, STEP_HALF_PERIOD=2, SETTLE_CYCLES=3.
REQ-033 next_move=5'b00010 (R, inverse=0), start -> en_pins=6'b000001, dir_pin=1, 4 step pulses each 2 high and 2 low, move_done at cycle 20 after accept.
REQ-034 next_move=5'b10101 (U half turn, inverse) -> en_pins=6'b000010, dir_pin=0, 8 pulses, move_done at cycle 36.
REQ-035 next_move=5'b00000 and then 5'b01110 -> move_error pulse of one cycle each; en_pins stays 0; move_done never fires.
REQ-036 Reset asserted at cycle 7 of a move -> next edge has en_pins=0, step_pin=0, move_ready=1; no move_done pulse.
REQ-037 move_start held high across a whole move with next_move=F -> exactly one move runs per IDLE window; the second move is accepted in the cycle after move_done.
